// File: rtl/rtc_capture_bank.sv
// rtc_capture_bank
// Captures one RTC transfer sequence per vertical blank into a shadow bank.
// Each captured byte is converted to two ASCII digits. The shadow bank is
// copied into the display bank in a single commit cycle, so the display
// never shows a half-updated set of fields.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   vblank            - display is outside the visible area
//   seq_start         - one-cycle pulse that starts an RTC sequence
//   data_in/data_valid- RTC data beat and its qualifier
//   rd_idx            - display-side field index
//   rd_tens/rd_units  - registered ASCII digits of field rd_idx
//   busy              - FSM is not idle
//   done / abort      - one-cycle pulses: bank committed / sequence discarded
//   fmt_err           - sticky flag for an unconvertible captured byte
module rtc_capture_bank #(
  parameter int NFIELDS = 11,
  parameter int SKIP    = 4,
  parameter bit BCD_IN  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       seq_start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic [3:0] rd_idx,
  output logic [6:0] rd_tens,
  output logic [6:0] rd_units,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic       fmt_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  localparam logic [3:0] SKIP_LAST  = 4'(SKIP - 1);
  localparam logic [3:0] FIELD_LAST = 4'(NFIELDS - 1);
  localparam logic [4:0] NF_LIMIT   = 5'(NFIELDS);

  // Returns {err, tens, units}; unconvertible bytes become '?','?'.
  function automatic logic [14:0] convert_byte(input logic [7:0] v, input logic bcd);
    logic [14:0] res;
    res = {1'b1, 7'h3F, 7'h3F};
    if (bcd) begin
      if ((v[7:4] <= 4'd9) && (v[3:0] <= 4'd9)) begin
        res = {1'b0, 7'h30 + {3'd0, v[7:4]}, 7'h30 + {3'd0, v[3:0]}};
      end
    end else begin
      if (v <= 8'd99) begin
        res = {1'b0, 7'h30 + 7'(v / 8'd10), 7'h30 + 7'(v % 8'd10)};
      end
    end
    return res;
  endfunction

  state_t      state_r;
  logic        armed_r;
  logic [3:0]  beat_cnt_r;
  logic [3:0]  field_idx_r;
  logic        seq_err_r;
  logic        busy_r;
  logic        done_r;
  logic        abort_r;
  logic        fmt_err_r;
  logic [6:0]  shadow_tens_r  [16];
  logic [6:0]  shadow_units_r [16];
  logic [6:0]  disp_tens_r    [16];
  logic [6:0]  disp_units_r   [16];
  logic [6:0]  rd_tens_r;
  logic [6:0]  rd_units_r;
  logic [14:0] conv_s;
  logic        conv_err_s;

  assign conv_s     = convert_byte(data_in, BCD_IN);
  assign conv_err_s = conv_s[14];

  // Sequence FSM, shadow capture, bank commit and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      armed_r     <= 1'b1;
      beat_cnt_r  <= 4'd0;
      field_idx_r <= 4'd0;
      seq_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
      fmt_err_r   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        shadow_tens_r[i]  <= 7'h30;
        shadow_units_r[i] <= 7'h30;
        disp_tens_r[i]    <= 7'h30;
        disp_units_r[i]   <= 7'h30;
      end
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      // One sequence per blank: re-arm only once the visible area is reached.
      if (state_r == ST_COMMIT) begin
        armed_r <= 1'b0;
      end else if (!vblank) begin
        armed_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (seq_start && vblank && armed_r) begin
            beat_cnt_r  <= 4'd0;
            field_idx_r <= 4'd0;
            seq_err_r   <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (!vblank) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else if (data_valid) begin
            if (beat_cnt_r == SKIP_LAST) begin
              state_r <= ST_CAPTURE;
            end
            beat_cnt_r <= beat_cnt_r + 4'd1;
          end
        end
        ST_CAPTURE: begin
          // A vblank fall wins over a simultaneous final beat.
          if (!vblank) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else if (data_valid) begin
            shadow_tens_r[field_idx_r]  <= conv_s[13:7];
            shadow_units_r[field_idx_r] <= conv_s[6:0];
            if (conv_err_s) begin
              fmt_err_r <= 1'b1;
              seq_err_r <= 1'b1;
            end
            if (field_idx_r == FIELD_LAST) begin
              state_r <= ST_COMMIT;
              done_r  <= 1'b1;
              // done and the cleared flag appear together for a clean sequence.
              if (!(seq_err_r || conv_err_s)) begin
                fmt_err_r <= 1'b0;
              end
            end else begin
              field_idx_r <= field_idx_r + 4'd1;
            end
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NFIELDS; i++) begin
            disp_tens_r[i]  <= shadow_tens_r[i];
            disp_units_r[i] <= shadow_units_r[i];
          end
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Registered display read port; indices past the last field read as spaces.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_tens_r  <= 7'h30;
      rd_units_r <= 7'h30;
    end else if ({1'b0, rd_idx} >= NF_LIMIT) begin
      rd_tens_r  <= 7'h20;
      rd_units_r <= 7'h20;
    end else begin
      rd_tens_r  <= disp_tens_r[rd_idx];
      rd_units_r <= disp_units_r[rd_idx];
    end
  end

  assign rd_tens  = rd_tens_r;
  assign rd_units = rd_units_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign abort    = abort_r;
  assign fmt_err  = fmt_err_r;

endmodule

// File: tb/tb_rtc_capture_bank.sv
// Directed bench for rtc_capture_bank: a default binary instance, a BCD
// instance and a SKIP=0/NFIELDS=1 instance share one stimulus bus; each
// phase resets all three and checks only the instance it targets.
module tb_rtc_capture_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic       vblank;
  logic       seq_start;
  logic [7:0] data_in;
  logic       data_valid;
  logic [3:0] rd_idx;

  logic [6:0] d_tens, d_units, b_tens, b_units, z_tens, z_units;
  logic d_busy, d_done, d_abort, d_fmt;
  logic b_busy, b_done, b_abort, b_fmt;
  logic z_busy, z_done, z_abort, z_fmt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_capture_bank u_dflt (
    .clk(clk), .reset(reset), .vblank(vblank), .seq_start(seq_start),
    .data_in(data_in), .data_valid(data_valid), .rd_idx(rd_idx),
    .rd_tens(d_tens), .rd_units(d_units), .busy(d_busy), .done(d_done),
    .abort(d_abort), .fmt_err(d_fmt));

  rtc_capture_bank #(.BCD_IN(1'b1)) u_bcd (
    .clk(clk), .reset(reset), .vblank(vblank), .seq_start(seq_start),
    .data_in(data_in), .data_valid(data_valid), .rd_idx(rd_idx),
    .rd_tens(b_tens), .rd_units(b_units), .busy(b_busy), .done(b_done),
    .abort(b_abort), .fmt_err(b_fmt));

  rtc_capture_bank #(.SKIP(0), .NFIELDS(1)) u_s0 (
    .clk(clk), .reset(reset), .vblank(vblank), .seq_start(seq_start),
    .data_in(data_in), .data_valid(data_valid), .rd_idx(rd_idx),
    .rd_tens(z_tens), .rd_units(z_units), .busy(z_busy), .done(z_done),
    .abort(z_abort), .fmt_err(z_fmt));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v);
    data_in    = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic start_seq();
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; vblank = 1'b0; seq_start = 1'b0;
    data_valid = 1'b0; data_in = 8'd0; rd_idx = 4'd0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_tens", {25'd0, d_tens}, 32'h30);
    check_eq("rst_units", {25'd0, d_units}, 32'h30);
    check_eq("rst_flags", {28'd0, d_busy, d_done, d_abort, d_fmt}, 32'h0);

    // Default capture: 15 beats 0..14, fields hold 4..14
    vblank = 1'b1;
    start_seq();
    check_eq("seq_busy", {31'd0, d_busy}, 32'd1);
    for (int i = 0; i < 14; i++) beat(8'(i));
    check_eq("pre_done", {31'd0, d_done}, 32'd0);
    beat(8'd14);
    check_eq("done_pulse", {31'd0, d_done}, 32'd1);
    tick();
    check_eq("done_low", {30'd0, d_done, d_busy}, 32'd0);
    rd_idx = 4'd0; tick();
    check_eq("f0", {18'd0, d_tens, d_units}, {18'd0, 7'h30, 7'h34});
    rd_idx = 4'd10; tick();
    check_eq("f10", {18'd0, d_tens, d_units}, {18'd0, 7'h31, 7'h34});

    // Second start in the same blank is ignored; re-arm after vblank low
    start_seq();
    check_eq("rearm_block", {31'd0, d_busy}, 32'd0);
    vblank = 1'b0; tick();
    vblank = 1'b1; tick();
    start_seq();
    check_eq("rearm_ok", {31'd0, d_busy}, 32'd1);

    // Abort after 7 beats: display keeps reset digits
    do_reset();
    vblank = 1'b1;
    start_seq();
    for (int i = 0; i < 7; i++) beat(8'(20 + i));
    vblank = 1'b0; tick();
    check_eq("abort_pulse", {29'd0, d_abort, d_done, d_busy}, 32'b100);
    tick();
    check_eq("abort_low", {30'd0, d_abort, d_done}, 32'd0);
    rd_idx = 4'd0; tick();
    check_eq("abort_disp", {18'd0, d_tens, d_units}, {18'd0, 7'h30, 7'h30});

    // Binary out-of-range byte and out-of-range read index
    do_reset();
    vblank = 1'b1;
    start_seq();
    for (int i = 0; i < 4; i++) beat(8'd0);
    beat(8'd100);
    check_eq("bin_fmt", {31'd0, d_fmt}, 32'd1);
    for (int i = 0; i < 10; i++) beat(8'd5);
    check_eq("bin_done", {31'd0, d_done}, 32'd1);
    tick();
    rd_idx = 4'd0; tick();
    check_eq("bin_q", {18'd0, d_tens, d_units}, {18'd0, 7'h3F, 7'h3F});
    rd_idx = 4'd1; tick();
    check_eq("bin_f1", {18'd0, d_tens, d_units}, {18'd0, 7'h30, 7'h35});
    rd_idx = 4'd12; tick();
    check_eq("idx12", {18'd0, d_tens, d_units}, {18'd0, 7'h20, 7'h20});

    // BCD conversion, error, and clear on clean sequence
    do_reset();
    vblank = 1'b1;
    start_seq();
    for (int i = 0; i < 4; i++) beat(8'd0);
    beat(8'h59);
    beat(8'h5A);
    check_eq("bcd_fmt", {31'd0, b_fmt}, 32'd1);
    for (int i = 0; i < 9; i++) beat(8'h01);
    check_eq("bcd_done", {31'd0, b_done}, 32'd1);
    tick();
    rd_idx = 4'd0; tick();
    check_eq("bcd_59", {18'd0, b_tens, b_units}, {18'd0, 7'h35, 7'h39});
    rd_idx = 4'd1; tick();
    check_eq("bcd_5a", {18'd0, b_tens, b_units}, {18'd0, 7'h3F, 7'h3F});
    vblank = 1'b0; tick();
    vblank = 1'b1;
    start_seq();
    for (int i = 0; i < 14; i++) beat(8'h12);
    check_eq("bcd_sticky", {31'd0, b_fmt}, 32'd1);
    beat(8'h12);
    check_eq("bcd_clr", {30'd0, b_done, b_fmt}, 32'b10);
    tick();
    rd_idx = 4'd1; tick();
    check_eq("bcd_12", {18'd0, b_tens, b_units}, {18'd0, 7'h31, 7'h32});

    // SKIP=0, NFIELDS=1: beat with seq_start is ignored
    do_reset();
    vblank = 1'b1;
    seq_start = 1'b1; data_in = 8'd37; data_valid = 1'b1;
    tick();
    seq_start = 1'b0; data_valid = 1'b0;
    check_eq("s0_first", {30'd0, z_busy, z_done}, 32'b10);
    beat(8'd37);
    check_eq("s0_done", {31'd0, z_done}, 32'd1);
    tick();
    rd_idx = 4'd0; tick();
    check_eq("s0_37", {18'd0, z_tens, z_units}, {18'd0, 7'h33, 7'h37});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
